decoder_3to8: RTL and testbench
===============================

Name: decoder_3to8

Overview:
- Registered 3-to-8 one-hot decoder: 3-bit address in, 8-bit one-hot pattern out, bit index equal to the address.
- Used as a line-select / chip-select generator.
- Driven in system test by the PATTERN_Decoder3x8 stimulus block, which supplies address and observes the pattern.
- Adds an enable, a configurable pipeline depth and configurable output polarity around the core decode.

Parameters:
- LATENCY, 1, register stages from address/en sample to Outpattern; legal values 1 or 2; any other value is a compile-time error.
- ACTIVE_LOW, 0, 0 = selected bit is 1 and others are 0; 1 = selected bit is 0 and others are 1.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; assertion clears state immediately, deassertion is synchronised by the user.
- en  input  1  decode enable, sampled on clk rising edge.
- address  input  3  line index to select, 0..7, sampled with en.
- Outpattern  output  8  registered decoded pattern.
- out_valid  output  1  high when Outpattern reflects a sampled address with en=1.

Behaviour:
- Idle pattern:
  - 8'h00 when ACTIVE_LOW=0.
  - 8'hFF when ACTIVE_LOW=1.
- Reset (rst_n=0, asynchronous):
  - Outpattern = idle pattern.
  - out_valid = 0.
  - All internal pipeline stages cleared to idle/invalid, without waiting for clk.
- Decode function:
  - ACTIVE_LOW=0: pattern bit i = 1 iff address==i; all other bits 0.
  - ACTIVE_LOW=1: the bitwise inverse of the ACTIVE_LOW=0 pattern.
  - address=0 -> 8'h01, 1 -> 8'h02, 2 -> 8'h04, 3 -> 8'h08, 4 -> 8'h10, 5 -> 8'h20, 6 -> 8'h40, 7 -> 8'h80 (ACTIVE_LOW=0).
- Enable rules:
  - en=1 at edge N: the decoded pattern and out_valid=1 appear after edge N+LATENCY-1 (LATENCY=1: visible right after edge N).
  - en=0 at edge N: idle pattern and out_valid=0 appear at the same latency. Outputs do not hold the previous value.
- Throughput: one decode per cycle. A new address every cycle produces a new pattern every cycle, in order, with no bubbles.
- Pipeline (LATENCY=2):
  - Stage 1 registers en and the decoded pattern.
  - Stage 2 registers the stage-1 values to the outputs.
  - Both stages are reset asynchronously.
- Output invariants:
  - Outpattern is always one-hot (ACTIVE_LOW=0), one-cold (ACTIVE_LOW=1), or the idle pattern. No other value is ever driven.
  - out_valid=1 implies Outpattern is not the idle pattern.
- Reset mid-stream: all in-flight decodes are discarded. The first valid output after release comes LATENCY cycles after the first en=1 sample following rst_n deassertion.
- Unknown/X on address while en=1: not required to be handled. The bench drives only known values.
- No combinational path from address or en to any output.

Test Plan:
- Reset check: hold rst_n=0 with en=1, address=3 -> Outpattern=8'h00, out_valid=0 throughout, including between clock edges.
- Full sweep (LATENCY=1, ACTIVE_LOW=0): en=1, address 0..7 on consecutive cycles -> Outpattern 8'h01, 02, 04, 08, 10, 20, 40, 80 on consecutive cycles, out_valid=1 each cycle.
- Enable gating: en=1 with address=5, then en=0 with address=2 -> 8'h20/out_valid=1, then 8'h00/out_valid=0 the next cycle.
- Latency 2: LATENCY=2, en=1, address=6 at edge N, then address=1 at edge N+1 -> 8'h40 after edge N+1, 8'h02 after edge N+2.
- Polarity: ACTIVE_LOW=1, address=4, en=1 -> Outpattern=8'hEF; en=0 -> 8'hFF; reset -> 8'hFF.
- Mid-stream reset: LATENCY=2, assert rst_n=0 between edges while a decode is in flight -> outputs go to idle/invalid immediately; after release, the in-flight value never appears.

Source files
------------

// File: rtl/decoder_3to8_if.sv
// Decode request / pattern bus between a line-select user and decoder_3to8.
interface decoder_3to8_if;
  logic       en;
  logic [2:0] address;
  logic [7:0] Outpattern;
  logic       out_valid;

  modport master (output en, output address, input Outpattern, input out_valid);
  modport slave  (input en, input address, output Outpattern, output out_valid);
endinterface

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot (or one-cold) line-select decoder with enable
// and a 1- or 2-stage pipeline.
module decoder_3to8 #(
  parameter int unsigned LATENCY    = 1,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_3to8_if.slave  bus
);

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned PAT_W  = 8;
  localparam logic [PAT_W-1:0] IDLE_PAT = ACTIVE_LOW ? {PAT_W{1'b1}} : {PAT_W{1'b0}};

  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
    $error("decoder_3to8: LATENCY must be 1 or 2");
  end

  logic [PAT_W-1:0]  pat_d;
  logic              vld_d;
  logic [PAT_W-1:0]  out_pat_q;
  logic              out_vld_q;
  logic [ADDR_W-1:0] addr_c;

  assign addr_c = bus.address;

  // XOR with the idle pattern turns one-hot into one-cold for active-low use.
  always_comb begin
    pat_d = IDLE_PAT;
    vld_d = 1'b0;
    if (bus.en) begin
      pat_d = (PAT_W'(1) << addr_c) ^ IDLE_PAT;
      vld_d = 1'b1;
    end
  end

  if (LATENCY == 2) begin : g_lat2
    logic [PAT_W-1:0] s1_pat_q;
    logic             s1_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_pat_q  <= IDLE_PAT;
        s1_vld_q  <= 1'b0;
        out_pat_q <= IDLE_PAT;
        out_vld_q <= 1'b0;
      end else begin
        s1_pat_q  <= pat_d;
        s1_vld_q  <= vld_d;
        out_pat_q <= s1_pat_q;
        out_vld_q <= s1_vld_q;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_pat_q <= IDLE_PAT;
        out_vld_q <= 1'b0;
      end else begin
        out_pat_q <= pat_d;
        out_vld_q <= vld_d;
      end
    end
  end

  assign bus.Outpattern = out_pat_q;
  assign bus.out_valid  = out_vld_q;

endmodule

// File: tb/tb_decoder_3to8.sv
// Bench for decoder_3to8: four parameterisations checked every cycle against a
// sample-history model, plus hand-computed directed expectations.
module tb_decoder_3to8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] address;

  int checks = 0;
  int passed = 0;

  decoder_3to8_if bus_l1 ();
  decoder_3to8_if bus_l2 ();
  decoder_3to8_if bus_a1 ();
  decoder_3to8_if bus_a2 ();

  assign bus_l1.en = en;  assign bus_l1.address = address;
  assign bus_l2.en = en;  assign bus_l2.address = address;
  assign bus_a1.en = en;  assign bus_a1.address = address;
  assign bus_a2.en = en;  assign bus_a2.address = address;

  decoder_3to8 #(.LATENCY(1), .ACTIVE_LOW(1'b0)) dut_l1 (.clk(clk), .rst_n(rst_n), .bus(bus_l1));
  decoder_3to8 #(.LATENCY(2), .ACTIVE_LOW(1'b0)) dut_l2 (.clk(clk), .rst_n(rst_n), .bus(bus_l2));
  decoder_3to8 #(.LATENCY(1), .ACTIVE_LOW(1'b1)) dut_a1 (.clk(clk), .rst_n(rst_n), .bus(bus_a1));
  decoder_3to8 #(.LATENCY(2), .ACTIVE_LOW(1'b1)) dut_a2 (.clk(clk), .rst_n(rst_n), .bus(bus_a2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: remember the last two accepted (en, address) samples; a LATENCY=L
  // decoder shows the sample taken L edges ago, counting the latest as one.
  bit       hist_v [2] = '{1'b0, 1'b0};
  int       hist_a [2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_v[0] = 1'b0; hist_v[1] = 1'b0;
    end else begin
      hist_v[1] = hist_v[0]; hist_a[1] = hist_a[0];
      hist_v[0] = en;        hist_a[0] = int'(address);
    end
  end

  function automatic logic [7:0] model_pat(int lat, bit al);
    logic [7:0] p;
    p = hist_v[lat-1] ? 8'(2 ** hist_a[lat-1]) : 8'h00;
    return al ? ~p : p;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    else
      passed++;
  endtask

  // Per-cycle compare of every instance against the model, mid-cycle.
  always @(negedge clk) begin
    chk("model_l1_pat", bus_l1.Outpattern, model_pat(1, 1'b0));
    chk("model_l1_vld", 8'(bus_l1.out_valid), 8'(hist_v[0]));
    chk("model_l2_pat", bus_l2.Outpattern, model_pat(2, 1'b0));
    chk("model_l2_vld", 8'(bus_l2.out_valid), 8'(hist_v[1]));
    chk("model_a1_pat", bus_a1.Outpattern, model_pat(1, 1'b1));
    chk("model_a1_vld", 8'(bus_a1.out_valid), 8'(hist_v[0]));
    chk("model_a2_pat", bus_a2.Outpattern, model_pat(2, 1'b1));
    chk("model_a2_vld", 8'(bus_a2.out_valid), 8'(hist_v[1]));
  end

  task automatic drive(input logic e, input logic [2:0] a);
    en = e;
    address = a;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 3'd3);

    // Reset held with en=1: idle both right after edges and between them.
    repeat (3) begin
      edge1();
      chk("rst_l1_pat", bus_l1.Outpattern, 8'h00);
      chk("rst_l1_vld", 8'(bus_l1.out_valid), 8'h00);
      chk("rst_a1_pat", bus_a1.Outpattern, 8'hFF);
      #3;
      chk("rst_l2_pat_mid", bus_l2.Outpattern, 8'h00);
      chk("rst_a2_pat_mid", bus_a2.Outpattern, 8'hFF);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i));
      edge1();
      chk("sweep_pat", bus_l1.Outpattern, sweep_tbl[i]);
      chk("sweep_vld", 8'(bus_l1.out_valid), 8'h01);
    end

    drive(1'b1, 3'd5);
    edge1();
    chk("gate_on_pat", bus_l1.Outpattern, 8'h20);
    chk("gate_on_vld", 8'(bus_l1.out_valid), 8'h01);
    chk("gate_on_al", bus_a1.Outpattern, 8'hDF);
    drive(1'b0, 3'd2);
    edge1();
    chk("gate_off_pat", bus_l1.Outpattern, 8'h00);
    chk("gate_off_vld", 8'(bus_l1.out_valid), 8'h00);
    chk("gate_off_al", bus_a1.Outpattern, 8'hFF);

    drive(1'b1, 3'd6);
    edge1();
    drive(1'b1, 3'd1);
    edge1();
    chk("lat2_first", bus_l2.Outpattern, 8'h40);
    chk("lat2_first_vld", 8'(bus_l2.out_valid), 8'h01);
    drive(1'b0, 3'd0);
    edge1();
    chk("lat2_second", bus_l2.Outpattern, 8'h02);
    edge1();
    chk("lat2_idle", bus_l2.Outpattern, 8'h00);
    chk("lat2_idle_vld", 8'(bus_l2.out_valid), 8'h00);

    drive(1'b1, 3'd4);
    edge1();
    chk("pol_sel", bus_a1.Outpattern, 8'hEF);
    drive(1'b0, 3'd4);
    edge1();
    chk("pol_idle", bus_a1.Outpattern, 8'hFF);
    chk("pol_idle_vld", 8'(bus_a1.out_valid), 8'h00);
    drive(1'b1, 3'd4);
    edge1();
    chk("pol_sel2", bus_a1.Outpattern, 8'hEF);
    #2 rst_n = 1'b0;
    #1;
    chk("pol_rst", bus_a1.Outpattern, 8'hFF);
    chk("pol_rst_vld", 8'(bus_a1.out_valid), 8'h00);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Address 7 sits in stage 1 of the 2-deep pipe when reset hits.
    drive(1'b1, 3'd4);
    edge1();
    drive(1'b1, 3'd7);
    edge1();
    chk("mid_before", bus_l2.Outpattern, 8'h10);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_pat", bus_l2.Outpattern, 8'h00);
    chk("mid_rst_vld", 8'(bus_l2.out_valid), 8'h00);
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive(1'b0, 3'd7);
    repeat (3) begin
      edge1();
      chk("mid_no_stale", bus_l2.Outpattern, 8'h00);
      chk("mid_no_stale_vld", 8'(bus_l2.out_valid), 8'h00);
    end
    drive(1'b1, 3'd3);
    edge1();
    chk("post_l1", bus_l1.Outpattern, 8'h08);
    chk("post_l2_wait", bus_l2.Outpattern, 8'h00);
    drive(1'b1, 3'd0);
    edge1();
    chk("post_l2", bus_l2.Outpattern, 8'h08);
    chk("post_l2_vld", 8'(bus_l2.out_valid), 8'h01);
    chk("post_a2", bus_a2.Outpattern, 8'hF7);

    // Mixed back-to-back traffic, checked by the model only.
    for (int i = 0; i < 16; i++) begin
      drive(1'((i % 3) != 2), 3'((i * 5) % 8));
      edge1();
    end
    drive(1'b0, 3'd0);
    repeat (3) edge1();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
